// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampling UART receiver (7/8 data bits, optional parity, 1/2 stop bits).
// Build option: define UART_RX_MAJORITY_EN for a 3-sample majority vote at sub-ticks 6/7/8.
module uart_rx #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       data_in,
  input  logic [1:0] buad_rate,
  input  logic [1:0] parity_type,
  input  logic       stop_bits,
  input  logic       data_length,
  output logic [7:0] data_out,
  output logic       rx_done,
  output logic       rx_active,
  output logic       parity_error,
  output logic       stop_error
);

  function automatic int div_of(input int baud);
    return (CLK_HZ + 8 * baud) / (16 * baud);
  endfunction

  localparam int CW = $clog2(div_of(4800) + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state_reg, state_next;

  // Terminal count (DIV-1) for each baud select, fixed at elaboration.
  logic [CW-1:0] div_tab [4];
  for (genvar gi = 0; gi < 4; gi++) begin : g_div
    assign div_tab[gi] = CW'(div_of(4800 << gi) - 1);
  end

  logic [1:0]    sync_reg;
  logic [1:0]    valid_reg;
  logic          prev_reg;
  logic          armed_reg;
  logic [1:0]    baud_sel_reg;
  logic [1:0]    par_sel_reg;
  logic          two_stop_reg;
  logic          len8_reg;
  logic [CW-1:0] cnt_reg;
  logic [3:0]    sub_reg;
  logic [2:0]    bit_reg;
  logic [7:0]    shift_reg;
  logic          stop_idx_reg;
  logic          stop_err_reg;
  logic          parity_ok_reg;
  logic [7:0]    data_out_reg;
  logic          done_reg;
  logic          perr_reg;
  logic          serr_reg;

  logic line;
  logic fall;
  logic tick;
  logic decide;
  logic bit_val;
  logic last_data;
  logic par_en;
  logic complete;

  assign line      = sync_reg[1];
  assign fall      = armed_reg & prev_reg & ~line;
  assign tick      = (state_reg != IDLE) && (cnt_reg == div_tab[baud_sel_reg]);
  assign last_data = (bit_reg == (len8_reg ? 3'd7 : 3'd6));
  assign par_en    = (par_sel_reg == 2'b01) || (par_sel_reg == 2'b10);

  // The sub-counter free-runs across bits, so sub-tick 7 of every bit is mid-bit.
`ifdef UART_RX_MAJORITY_EN
  logic s6_reg;
  logic s7_reg;

  assign decide  = tick && (sub_reg == 4'd8);
  assign bit_val = (s6_reg & s7_reg) | (s6_reg & line) | (s7_reg & line);

  always_ff @(posedge clock) begin
    if (rst) begin
      s6_reg <= 1'b1;
      s7_reg <= 1'b1;
    end else if (tick && sub_reg == 4'd6) begin
      s6_reg <= line;
    end else if (tick && sub_reg == 4'd7) begin
      s7_reg <= line;
    end
  end
`else
  assign decide  = tick && (sub_reg == 4'd7);
  assign bit_val = line;
`endif

  always_ff @(posedge clock) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    complete   = 1'b0;
    case (state_reg)
      IDLE:   if (fall) state_next = START;
      START:  if (decide) state_next = bit_val ? IDLE : DATA;
      DATA:   if (decide && last_data) state_next = par_en ? PARITY : STOP;
      PARITY: if (decide) state_next = STOP;
      STOP: begin
        // Leave at the last stop sample so a following start edge is not missed.
        if (decide && (!two_stop_reg || stop_idx_reg)) begin
          state_next = IDLE;
          complete   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      sync_reg      <= 2'b11;
      valid_reg     <= 2'b00;
      prev_reg      <= 1'b1;
      armed_reg     <= 1'b0;
      baud_sel_reg  <= 2'b00;
      par_sel_reg   <= 2'b00;
      two_stop_reg  <= 1'b0;
      len8_reg      <= 1'b0;
      cnt_reg       <= '0;
      sub_reg       <= 4'd0;
      bit_reg       <= 3'd0;
      shift_reg     <= 8'h00;
      stop_idx_reg  <= 1'b0;
      stop_err_reg  <= 1'b0;
      parity_ok_reg <= 1'b0;
      data_out_reg  <= 8'h00;
      done_reg      <= 1'b0;
      perr_reg      <= 1'b0;
      serr_reg      <= 1'b0;
    end else begin
      sync_reg  <= {sync_reg[0], data_in};
      valid_reg <= {valid_reg[0], 1'b1};
      prev_reg  <= line;
      // Arm only on a high level that really came through the synchronizer.
      if (valid_reg[1] && line) armed_reg <= 1'b1;
      done_reg <= complete;

      if (state_reg == IDLE) begin
        cnt_reg <= '0;
        sub_reg <= 4'd0;
      end else if (tick) begin
        cnt_reg <= '0;
        sub_reg <= sub_reg + 4'd1;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end

      if (state_reg == IDLE && fall) begin
        baud_sel_reg  <= buad_rate;
        par_sel_reg   <= parity_type;
        two_stop_reg  <= stop_bits;
        len8_reg      <= data_length;
        bit_reg       <= 3'd0;
        shift_reg     <= 8'h00;
        stop_idx_reg  <= 1'b0;
        stop_err_reg  <= 1'b0;
        parity_ok_reg <= 1'b0;
      end

      if (decide) begin
        case (state_reg)
          DATA: begin
            shift_reg[bit_reg] <= bit_val;
            bit_reg            <= bit_reg + 3'd1;
          end
          PARITY: parity_ok_reg <= ((^shift_reg) ^ bit_val) == (par_sel_reg == 2'b01);
          STOP: begin
            stop_idx_reg <= 1'b1;
            stop_err_reg <= stop_err_reg | ~bit_val;
          end
          default: ;
        endcase
      end

      if (complete) begin
        data_out_reg <= shift_reg;
        perr_reg     <= par_en & ~parity_ok_reg;
        serr_reg     <= stop_err_reg | ~bit_val;
      end
    end
  end

  assign data_out     = data_out_reg;
  assign rx_done      = done_reg;
  assign rx_active    = (state_reg != IDLE);
  assign parity_error = perr_reg;
  assign stop_error   = serr_reg;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives randomized and directed serial frames into uart_rx and checks
// every received frame against a frame-level reference model kept in the bench.
module tb_uart_rx;
  localparam int CLK_HZ = 1_000_000;

  logic       clock = 1'b0;
  logic       rst = 1'b1;
  logic       data_in = 1'b1;
  logic [1:0] buad_rate = 2'b00;
  logic [1:0] parity_type = 2'b00;
  logic       stop_bits = 1'b0;
  logic       data_length = 1'b1;
  logic [7:0] data_out;
  logic       rx_done;
  logic       rx_active;
  logic       parity_error;
  logic       stop_error;

  int errors = 0;
  int checks = 0;
  int unsigned cyc = 0;
  int unsigned start_cyc = 0;
  logic [7:0]  got_d[$];
  bit          got_pe[$];
  bit          got_se[$];
  int unsigned got_cyc[$];
  logic [7:0]  exp_d[$];
  bit          exp_pe[$];
  bit          exp_se[$];
  int done_wide = 0;
  logic done_prev = 1'b0;

  always #5 clock = ~clock;

  uart_rx #(.CLK_HZ(CLK_HZ)) dut (
    .clock(clock), .rst(rst), .data_in(data_in), .buad_rate(buad_rate),
    .parity_type(parity_type), .stop_bits(stop_bits), .data_length(data_length),
    .data_out(data_out), .rx_done(rx_done), .rx_active(rx_active),
    .parity_error(parity_error), .stop_error(stop_error)
  );

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (rx_done) begin
      got_d.push_back(data_out);
      got_pe.push_back(parity_error);
      got_se.push_back(stop_error);
      got_cyc.push_back(cyc);
      $display("rx frame %0d: data=%02h parity_error=%0b stop_error=%0b cycle=%0d",
               got_d.size() - 1, data_out, parity_error, stop_error, cyc);
    end
    if (rx_done && done_prev) done_wide++;
    done_prev = rx_done;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog");
  end

  function automatic int divof(input logic [1:0] sel);
    int baud;
    baud = 4800 << sel;
    return (CLK_HZ + 8 * baud) / (16 * baud);
  endfunction

  task automatic drive(input logic v, input int n);
    data_in = v;
    repeat (n) @(negedge clock);
  endtask

  // Reference model: builds the line waveform bit by bit and records the expected result.
  task automatic send_frame(input logic [7:0] d, input logic [1:0] br, input logic [1:0] pt,
                            input logic sb, input logic dl, input bit bad_par,
                            input bit bad_stop, input bit scramble);
    int bt;
    int nb;
    logic p;
    logic [7:0] dm;
    bt = 16 * divof(br);
    nb = dl ? 8 : 7;
    dm = dl ? d : {1'b0, d[6:0]};
    buad_rate = br; parity_type = pt; stop_bits = sb; data_length = dl;
    start_cyc = cyc;
    drive(1'b0, bt);
    if (scramble) begin
      buad_rate = 2'($urandom); parity_type = 2'($urandom);
      stop_bits = 1'($urandom); data_length = 1'($urandom);
    end
    for (int i = 0; i < nb; i++) drive(d[i], bt);
    if (pt == 2'b01 || pt == 2'b10) begin
      p = ^dm;
      if (pt == 2'b01) p = ~p;
      drive(p ^ bad_par, bt);
    end
    if (sb) drive(1'b1, bt);
    drive(!bad_stop, bt);
    if (bad_stop) drive(1'b1, bt);
    exp_d.push_back(dm);
    exp_pe.push_back((pt == 2'b01 || pt == 2'b10) && bad_par);
    exp_se.push_back(bad_stop);
  endtask

  task automatic wait_count(input int n, input int budget);
    int k;
    k = 0;
    while (got_d.size() < n && k < budget) begin
      @(negedge clock);
      k++;
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic test_reset();
    rst = 1'b1; data_in = 1'b1;
    repeat (4) @(negedge clock);
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out: got %02h want 00", data_out); end
    checks++; if (rx_done !== 1'b0) begin errors++; $display("FAIL reset_rx_done: got %b want 0", rx_done); end
    checks++; if (rx_active !== 1'b0) begin errors++; $display("FAIL reset_rx_active: got %b want 0", rx_active); end
    checks++; if (parity_error !== 1'b0) begin errors++; $display("FAIL reset_parity_error: got %b want 0", parity_error); end
    checks++; if (stop_error !== 1'b0) begin errors++; $display("FAIL reset_stop_error: got %b want 0", stop_error); end
    rst = 1'b0;
    repeat (8) @(negedge clock);
    checks++; if (rx_active !== 1'b0) begin errors++; $display("FAIL reset_idle_active: got %b want 0", rx_active); end
  endtask

  task automatic test_basic();
    int n0;
    n0 = exp_d.size();
    send_frame(8'h95, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 64);
    wait_count(exp_d.size(), 3000);
    checks++; if (got_d.size() !== exp_d.size()) begin errors++; $display("FAIL basic_count: got %0d want %0d", got_d.size(), exp_d.size()); end
    for (int i = n0; i < exp_d.size() && i < got_d.size(); i++) begin
      checks++; if (got_d[i] !== exp_d[i]) begin errors++; $display("FAIL basic_data[%0d]: got %02h want %02h", i, got_d[i], exp_d[i]); end
      checks++; if (got_pe[i] !== exp_pe[i]) begin errors++; $display("FAIL basic_parity[%0d]: got %b want %b", i, got_pe[i], exp_pe[i]); end
      checks++; if (got_se[i] !== exp_se[i]) begin errors++; $display("FAIL basic_stop[%0d]: got %b want %b", i, got_se[i], exp_se[i]); end
    end
    checks++; if (done_wide !== 0) begin errors++; $display("FAIL basic_done_width: got %0d wide pulses want 0", done_wide); end
  endtask

  task automatic test_odd_parity();
    int n0;
    n0 = exp_d.size();
    send_frame(8'hF5, 2'b01, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'hE7, 2'b01, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'hF5, 2'b01, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 64);
    wait_count(exp_d.size(), 3000);
    checks++; if (got_d.size() !== exp_d.size()) begin errors++; $display("FAIL odd_count: got %0d want %0d", got_d.size(), exp_d.size()); end
    for (int i = n0; i < exp_d.size() && i < got_d.size(); i++) begin
      checks++; if (got_d[i] !== exp_d[i]) begin errors++; $display("FAIL odd_data[%0d]: got %02h want %02h", i, got_d[i], exp_d[i]); end
      checks++; if (got_pe[i] !== exp_pe[i]) begin errors++; $display("FAIL odd_parity[%0d]: got %b want %b", i, got_pe[i], exp_pe[i]); end
      checks++; if (got_se[i] !== exp_se[i]) begin errors++; $display("FAIL odd_stop[%0d]: got %b want %b", i, got_se[i], exp_se[i]); end
    end
  endtask

  task automatic test_two_stop();
    int n0;
    n0 = exp_d.size();
    send_frame(8'hC7, 2'b10, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'hC7, 2'b10, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 64);
    wait_count(exp_d.size(), 3000);
    checks++; if (got_d.size() !== exp_d.size()) begin errors++; $display("FAIL two_stop_count: got %0d want %0d", got_d.size(), exp_d.size()); end
    for (int i = n0; i < exp_d.size() && i < got_d.size(); i++) begin
      checks++; if (got_d[i] !== exp_d[i]) begin errors++; $display("FAIL two_stop_data[%0d]: got %02h want %02h", i, got_d[i], exp_d[i]); end
      checks++; if (got_pe[i] !== exp_pe[i]) begin errors++; $display("FAIL two_stop_parity[%0d]: got %b want %b", i, got_pe[i], exp_pe[i]); end
      checks++; if (got_se[i] !== exp_se[i]) begin errors++; $display("FAIL two_stop_stop[%0d]: got %b want %b", i, got_se[i], exp_se[i]); end
    end
  endtask

  task automatic test_glitch();
    int n0;
    int k;
    int div;
    bit saw;
    n0 = got_d.size();
    div = divof(2'b01);
    buad_rate = 2'b01; parity_type = 2'b00; stop_bits = 1'b0; data_length = 1'b1;
    saw = 1'b0;
    data_in = 1'b0;
    repeat (3 * div) begin
      @(negedge clock);
      if (rx_active) saw = 1'b1;
    end
    data_in = 1'b1;
    k = 0;
    while (k < 40 * div && !(saw && !rx_active)) begin
      @(negedge clock);
      if (rx_active) saw = 1'b1;
      k++;
    end
    repeat (16 * div) @(negedge clock);
    checks++; if (saw !== 1'b1) begin errors++; $display("FAIL glitch_active_seen: got %b want 1", saw); end
    checks++; if (rx_active !== 1'b0) begin errors++; $display("FAIL glitch_active_end: got %b want 0", rx_active); end
    checks++; if (got_d.size() !== n0) begin errors++; $display("FAIL glitch_no_done: got %0d frames want %0d", got_d.size(), n0); end
    checks++; if (data_out !== exp_d[$]) begin errors++; $display("FAIL glitch_data_hold: got %02h want %02h", data_out, exp_d[$]); end
    checks++; if (parity_error !== exp_pe[$]) begin errors++; $display("FAIL glitch_parity_hold: got %b want %b", parity_error, exp_pe[$]); end
    checks++; if (stop_error !== exp_se[$]) begin errors++; $display("FAIL glitch_stop_hold: got %b want %b", stop_error, exp_se[$]); end
  endtask

  task automatic test_seven_bit();
    int n0;
    int div;
    int unsigned want;
    int unsigned delta;
    n0 = exp_d.size();
    div = divof(2'b11);
    send_frame(8'h75, 2'b11, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 64);
    wait_count(exp_d.size(), 3000);
    checks++; if (got_d.size() !== exp_d.size()) begin errors++; $display("FAIL seven_count: got %0d want %0d", got_d.size(), exp_d.size()); end
    for (int i = n0; i < exp_d.size() && i < got_d.size(); i++) begin
      checks++; if (got_d[i] !== exp_d[i]) begin errors++; $display("FAIL seven_data[%0d]: got %02h want %02h", i, got_d[i], exp_d[i]); end
      checks++; if (got_pe[i] !== exp_pe[i]) begin errors++; $display("FAIL seven_parity[%0d]: got %b want %b", i, got_pe[i], exp_pe[i]); end
      // 3 cycles to detect the start, then 9.5 bit times of 16 ticks to the last stop sample.
      want = 3 + (9 * 16 + 8) * div;
      delta = got_cyc[i] - start_cyc;
      checks++; if (delta + 1 < want || delta > want + div + 1) begin errors++; $display("FAIL seven_latency: got %0d cycles want %0d", delta, want); end
    end
    checks++; if (data_out[7] !== 1'b0) begin errors++; $display("FAIL seven_bit7: got %b want 0", data_out[7]); end
  endtask

  task automatic test_reset_mid_frame();
    int n0;
    int bt;
    bit saw;
    bt = 16 * divof(2'b01);
    buad_rate = 2'b01; parity_type = 2'b00; stop_bits = 1'b0; data_length = 1'b1;
    drive(1'b0, bt);
    drive(1'b1, bt);
    drive(1'b0, bt);
    drive(1'b1, bt);
    drive(1'b0, bt / 2);
    rst = 1'b1;
    repeat (3) @(negedge clock);
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL midrst_data_out: got %02h want 00", data_out); end
    checks++; if (rx_active !== 1'b0) begin errors++; $display("FAIL midrst_rx_active: got %b want 0", rx_active); end
    checks++; if (rx_done !== 1'b0) begin errors++; $display("FAIL midrst_rx_done: got %b want 0", rx_done); end
    checks++; if (parity_error !== 1'b0) begin errors++; $display("FAIL midrst_parity_error: got %b want 0", parity_error); end
    checks++; if (stop_error !== 1'b0) begin errors++; $display("FAIL midrst_stop_error: got %b want 0", stop_error); end
    rst = 1'b0;
    saw = 1'b0;
    repeat (2 * bt) begin
      @(negedge clock);
      if (rx_active) saw = 1'b1;
    end
    checks++; if (saw !== 1'b0) begin errors++; $display("FAIL midrst_false_start: got %b want 0", saw); end
    drive(1'b1, bt);
    n0 = exp_d.size();
    checks++; if (got_d.size() !== n0) begin errors++; $display("FAIL midrst_no_done: got %0d frames want %0d", got_d.size(), n0); end
    send_frame(8'h3C, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 64);
    wait_count(exp_d.size(), 3000);
    checks++; if (got_d.size() !== exp_d.size()) begin errors++; $display("FAIL midrst_count: got %0d want %0d", got_d.size(), exp_d.size()); end
    for (int i = n0; i < exp_d.size() && i < got_d.size(); i++) begin
      checks++; if (got_d[i] !== exp_d[i]) begin errors++; $display("FAIL midrst_data[%0d]: got %02h want %02h", i, got_d[i], exp_d[i]); end
      checks++; if (got_se[i] !== exp_se[i]) begin errors++; $display("FAIL midrst_stop[%0d]: got %b want %b", i, got_se[i], exp_se[i]); end
    end
  endtask

  task automatic test_random();
    int n0;
    logic [1:0] br;
    n0 = exp_d.size();
    for (int f = 0; f < 8; f++) begin
      br = 2'($urandom_range(0, 3));
      send_frame(8'($urandom), br, 2'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), 1'b1);
      drive(1'b1, $urandom_range(0, 16 * divof(br)));
    end
    drive(1'b1, 64);
    wait_count(exp_d.size(), 6000);
    checks++; if (got_d.size() !== exp_d.size()) begin errors++; $display("FAIL random_count: got %0d want %0d", got_d.size(), exp_d.size()); end
    for (int i = n0; i < exp_d.size() && i < got_d.size(); i++) begin
      checks++; if (got_d[i] !== exp_d[i]) begin errors++; $display("FAIL random_data[%0d]: got %02h want %02h", i, got_d[i], exp_d[i]); end
      checks++; if (got_pe[i] !== exp_pe[i]) begin errors++; $display("FAIL random_parity[%0d]: got %b want %b", i, got_pe[i], exp_pe[i]); end
      checks++; if (got_se[i] !== exp_se[i]) begin errors++; $display("FAIL random_stop[%0d]: got %b want %b", i, got_se[i], exp_se[i]); end
    end
    checks++; if (done_wide !== 0) begin errors++; $display("FAIL random_done_width: got %0d wide pulses want 0", done_wide); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_odd_parity();
    test_two_stop();
    test_glitch();
    test_seven_bit();
    test_reset_mid_frame();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
